// File: rtl/fpu_sequencer.sv
// Issue/latency controller between EX and the multi-cycle FPU: gates the FPU
// clock enable for the op's pipeline depth, stalls the core, and captures the result.
module fpu_sequencer #(
  parameter int unsigned width    = 32,
  parameter int unsigned LAT_ADD  = 7,
  parameter int unsigned LAT_MUL  = 5,
  parameter int unsigned LAT_DIV  = 6,
  parameter int unsigned LAT_CMP  = 1,
  parameter int unsigned LAT_SQRT = 16,
  parameter int unsigned LAT_CVT  = 6,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             fpu_start,
  input  logic [3:0]       fpuOp_in,
  input  logic             flush,
  input  logic [width-1:0] fpuResult_in,
  output logic             fpu_sel,
  output logic [3:0]       fpuOp_out,
  output logic             fpu_stall,
  output logic             fpu_busy,
  output logic             fpu_done,
  output logic [width-1:0] fpu_result_q
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] lat_c;
  logic             issue_c;

  // Pipeline depth of the op presented by EX; undefined codes finish in one cycle
  always_comb begin
    lat_c = CNT_W'(1);
    case (fpuOp_in)
      4'b0000, 4'b0001:          lat_c = CNT_W'(LAT_ADD);
      4'b0010:                   lat_c = CNT_W'(LAT_MUL);
      4'b0011:                   lat_c = CNT_W'(LAT_DIV);
      4'b0100, 4'b0101, 4'b0111: lat_c = CNT_W'(LAT_CMP);
      4'b0110:                   lat_c = CNT_W'(LAT_SQRT);
      4'b1000, 4'b1001:          lat_c = CNT_W'(LAT_CVT);
      default:                   lat_c = CNT_W'(1);
    endcase
  end

  assign issue_c = (state_q == S_IDLE) && fpu_start && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (issue_c) begin
          op_d = fpuOp_in;
          if (lat_c <= CNT_W'(1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_BUSY;
            cnt_d   = lat_c - CNT_W'(1);
          end
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        // The instruction leaves EX at the end of this cycle, so start is ignored
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Result is taken at the closing edge of DONE and held until the next completion
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      fpu_result_q <= '0;
    end else if (state_q == S_DONE) begin
      fpu_result_q <= fpuResult_in;
    end
  end

  // Enable and stall are gated by clear so they drop the moment reset asserts
  assign fpu_sel   = clear && (issue_c || (state_q == S_BUSY));
  assign fpu_stall = clear && (issue_c || (state_q == S_BUSY));
  assign fpu_busy  = (state_q != S_IDLE);
  assign fpu_done  = (state_q == S_DONE);
  assign fpuOp_out = (state_q != S_IDLE) ? op_q : fpuOp_in;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Scoreboard bench for fpu_sequencer: stimulus queues expected completions,
// a monitor checks each done pulse (cycle, op, captured result).
module tb_fpu_sequencer;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         clear;
  logic         fpu_start;
  logic [3:0]   fpuOp_in;
  logic         flush;
  logic [W-1:0] fpuResult_in;
  logic         fpu_sel;
  logic [3:0]   fpuOp_out;
  logic         fpu_stall;
  logic         fpu_busy;
  logic         fpu_done;
  logic [W-1:0] fpu_result_q;

  fpu_sequencer dut (
    .clock        (clock),
    .clear        (clear),
    .fpu_start    (fpu_start),
    .fpuOp_in     (fpuOp_in),
    .flush        (flush),
    .fpuResult_in (fpuResult_in),
    .fpu_sel      (fpu_sel),
    .fpuOp_out    (fpuOp_out),
    .fpu_stall    (fpu_stall),
    .fpu_busy     (fpu_busy),
    .fpu_done     (fpu_done),
    .fpu_result_q (fpu_result_q)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] res;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Issue one op in the next cycle and follow it through DONE; start stays high
  // through DONE as EX would hold it while stalled
  task automatic run_op(input logic [3:0] op, input logic [3:0] alt,
                        input logic [W-1:0] res, input int lat);
    for (int i = 0; i <= lat; i++) begin
      next_cycle();
      if (i == 0) begin
        fpu_start    = 1'b1;
        flush        = 1'b0;
        fpuOp_in     = op;
        fpuResult_in = res;
        sb.push_back('{op: op, res: res, due: cyc + lat});
      end else begin
        fpuOp_in = alt;
      end
      @(negedge clock);
      chk("sel",    32'(fpu_sel),   32'(i < lat));
      chk("stall",  32'(fpu_stall), 32'(i < lat));
      chk("busy",   32'(fpu_busy),  32'(i > 0));
      chk("op_out", 32'(fpuOp_out), 32'(op));
    end
  endtask

  task automatic idle();
    next_cycle();
    fpu_start = 1'b0;
    flush     = 1'b0;
    @(negedge clock);
    chk("idle_sel",  32'(fpu_sel),  32'(0));
    chk("idle_busy", 32'(fpu_busy), 32'(0));
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clock);
      if (fpu_done === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1, want done=0 (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("done_cycle", 32'(cyc), 32'(mon_e.due));
          chk("done_op", 32'(fpuOp_out), 32'(mon_e.op));
          @(posedge clock);
          #2;
          chk("result_q", fpu_result_q, mon_e.res);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    clear        = 1'b0;
    fpu_start    = 1'b1;
    flush        = 1'b0;
    fpuOp_in     = 4'b0011;
    fpuResult_in = '1;
    #2;
    chk("rst_sel",    32'(fpu_sel),   32'(0));
    chk("rst_stall",  32'(fpu_stall), 32'(0));
    chk("rst_busy",   32'(fpu_busy),  32'(0));
    chk("rst_done",   32'(fpu_done),  32'(0));
    chk("rst_result", fpu_result_q,   32'h0);
    fpu_start = 1'b0;
    #10 clear = 1'b1;

    // FMUL
    run_op(4'b0010, 4'b0010, 32'h40A0_0000, 5);
    idle();
    // FSQRT
    run_op(4'b0110, 4'b0110, 32'h4000_0000, 16);
    idle();
    // FSGNJ with start held through DONE, then back-to-back min/max
    run_op(4'b0100, 4'b0100, 32'hBF80_0000, 1);
    run_op(4'b0101, 4'b0101, 32'h3F80_0000, 1);
    idle();
    // Undefined op completes in one cycle with a zero result
    run_op(4'b1011, 4'b1011, 32'h0, 1);
    idle();
    // FSUB with EX op changing mid-flight
    run_op(4'b0001, 4'b0000, 32'h1234_5678, 7);
    idle();

    // FADD flushed in cycle 3: no done, result unchanged
    next_cycle();
    fpu_start = 1'b1; fpuOp_in = 4'b0000; fpuResult_in = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("fl_sel0", 32'(fpu_sel), 32'(1));
    for (int i = 1; i <= 2; i++) begin
      next_cycle();
      @(negedge clock);
      chk("fl_busy", 32'(fpu_busy), 32'(1));
    end
    next_cycle();
    flush = 1'b1;
    @(negedge clock);
    chk("fl_busy3", 32'(fpu_busy), 32'(1));
    next_cycle();
    flush = 1'b0; fpu_start = 1'b0;
    @(negedge clock);
    chk("fl_busy4",  32'(fpu_busy),  32'(0));
    chk("fl_sel4",   32'(fpu_sel),   32'(0));
    chk("fl_stall4", 32'(fpu_stall), 32'(0));
    chk("fl_done4",  32'(fpu_done),  32'(0));
    repeat (3) next_cycle();
    chk("fl_result", fpu_result_q, 32'h1234_5678);

    // Flush alongside start in IDLE: not accepted
    next_cycle();
    fpu_start = 1'b1; flush = 1'b1; fpuOp_in = 4'b0010;
    @(negedge clock);
    chk("fli_sel",   32'(fpu_sel),   32'(0));
    chk("fli_stall", 32'(fpu_stall), 32'(0));
    idle();

    // Async reset in FDIV cycle 2
    next_cycle();
    fpu_start = 1'b1; fpuOp_in = 4'b0011; fpuResult_in = 32'hCAFE_F00D;
    next_cycle();
    @(negedge clock);
    chk("ar_busy1", 32'(fpu_busy), 32'(1));
    next_cycle();
    #2 clear = 1'b0;
    #1;
    chk("ar_sel",    32'(fpu_sel),   32'(0));
    chk("ar_stall",  32'(fpu_stall), 32'(0));
    chk("ar_busy",   32'(fpu_busy),  32'(0));
    chk("ar_done",   32'(fpu_done),  32'(0));
    chk("ar_result", fpu_result_q,   32'h0);
    next_cycle();
    fpu_start = 1'b0;
    #2 clear = 1'b1;
    run_op(4'b0011, 4'b0011, 32'hCAFE_F00D, 6);
    idle();

    repeat (3) next_cycle();
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
